// File: rtl/ascii_7seg.sv
// Registered ASCII-to-seven-segment decoder for a single display digit.
// Optional macro ASCII7SEG_ALPHA_EN adds H, L, P, U, O, n, r, t (case-insensitive).
module ascii_7seg #(
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] ascii_code,
  input  logic       ascii_valid,
  output logic [6:0] hex_seg,
  output logic       seg_valid,
  output logic       unsupported
);

  localparam logic [6:0] SEG_BLANK = 7'h00;
  localparam logic [6:0] SEG_DASH  = 7'h40;

  // Letters are matched in upper case; only a..z are folded so digits and symbols pass through.
  function automatic logic [7:0] fold_case(input logic [7:0] c);
    if (c >= 8'h61 && c <= 8'h7A) begin
      return c - 8'h20;
    end
    return c;
  endfunction

  // Returns {unsupported, segments g..a} with segments active-high.
  function automatic logic [7:0] decode(input logic [7:0] c);
    logic [7:0] r;
    case (c)
      8'h30:   r = {1'b0, 7'h3F};
      8'h31:   r = {1'b0, 7'h06};
      8'h32:   r = {1'b0, 7'h5B};
      8'h33:   r = {1'b0, 7'h4F};
      8'h34:   r = {1'b0, 7'h66};
      8'h35:   r = {1'b0, 7'h6D};
      8'h36:   r = {1'b0, 7'h7D};
      8'h37:   r = {1'b0, 7'h07};
      8'h38:   r = {1'b0, 7'h7F};
      8'h39:   r = {1'b0, 7'h6F};
      8'h41:   r = {1'b0, 7'h77};
      8'h42:   r = {1'b0, 7'h7C};
      8'h43:   r = {1'b0, 7'h39};
      8'h44:   r = {1'b0, 7'h5E};
      8'h45:   r = {1'b0, 7'h79};
      8'h46:   r = {1'b0, 7'h71};
      8'h20:   r = {1'b0, SEG_BLANK};
      8'h2D:   r = {1'b0, SEG_DASH};
`ifdef ASCII7SEG_ALPHA_EN
      8'h48:   r = {1'b0, 7'h76};
      8'h4C:   r = {1'b0, 7'h38};
      8'h50:   r = {1'b0, 7'h73};
      8'h55:   r = {1'b0, 7'h3E};
      8'h4F:   r = {1'b0, 7'h3F};
      8'h4E:   r = {1'b0, 7'h54};
      8'h52:   r = {1'b0, 7'h50};
      8'h54:   r = {1'b0, 7'h78};
`endif
      default: r = {1'b1, SEG_DASH};
    endcase
    return r;
  endfunction

  function automatic logic [6:0] drive_level(input logic [6:0] seg);
    return ACTIVE_LOW ? ~seg : seg;
  endfunction

  logic [7:0] w_folded;
  logic [7:0] w_decoded;

  assign w_folded  = fold_case(ascii_code);
  assign w_decoded = decode(w_folded);

  logic [6:0] r_hex_seg;
  logic       r_seg_valid;
  logic       r_unsupported;

  // Output register stage: one cycle from strobe to display.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_hex_seg     <= drive_level(SEG_BLANK);
      r_seg_valid   <= 1'b0;
      r_unsupported <= 1'b0;
    end else begin
      r_seg_valid <= ascii_valid;
      if (ascii_valid) begin
        r_hex_seg     <= drive_level(w_decoded[6:0]);
        r_unsupported <= w_decoded[7];
      end
    end
  end

  assign hex_seg     = r_hex_seg;
  assign seg_valid   = r_seg_valid;
  assign unsupported = r_unsupported;

endmodule

// File: tb/tb_ascii_7seg.sv
// Randomized bench for ascii_7seg: table-driven reference model plus literal anchor checks.
module tb_ascii_7seg;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] ascii_code;
  logic       ascii_valid;
  logic [6:0] seg_lo, seg_hi;
  logic       sv_lo, sv_hi, un_lo, un_hi;

  int checks = 0;
  int errors = 0;

  ascii_7seg #(.ACTIVE_LOW(1'b1)) dut_lo (
    .clk(clk), .reset(reset), .ascii_code(ascii_code), .ascii_valid(ascii_valid),
    .hex_seg(seg_lo), .seg_valid(sv_lo), .unsupported(un_lo)
  );

  ascii_7seg #(.ACTIVE_LOW(1'b0)) dut_hi (
    .clk(clk), .reset(reset), .ascii_code(ascii_code), .ascii_valid(ascii_valid),
    .hex_seg(seg_hi), .seg_valid(sv_hi), .unsupported(un_hi)
  );

  always #5 clk = ~clk;

  // Character lookup table: active-high pattern and "supported" flag for every code.
  logic [6:0] pat_tbl [256];
  bit         ok_tbl  [256];

  task automatic add_char(input logic [7:0] c, input logic [6:0] p);
    pat_tbl[c] = p;
    ok_tbl[c]  = 1'b1;
    if (c >= 8'h41 && c <= 8'h5A) begin
      pat_tbl[c + 8'h20] = p;
      ok_tbl[c + 8'h20]  = 1'b1;
    end
  endtask

  task automatic build_table();
    string      hexs;
    logic [6:0] hexp [16];
    hexs = "0123456789ABCDEF";
    hexp = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
             7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
    for (int i = 0; i < 256; i++) begin
      pat_tbl[i] = 7'h40;
      ok_tbl[i]  = 1'b0;
    end
    for (int i = 0; i < 16; i++) add_char(hexs[i], hexp[i]);
    add_char(8'h20, 7'h00);
    add_char(8'h2D, 7'h40);
`ifdef ASCII7SEG_ALPHA_EN
    begin
      string      al;
      logic [6:0] alp [8];
      al  = "HLPUONRT";
      alp = '{7'h76, 7'h38, 7'h73, 7'h3E, 7'h3F, 7'h54, 7'h50, 7'h78};
      for (int i = 0; i < 8; i++) add_char(al[i], alp[i]);
    end
`endif
  endtask

  // Reference model state: what the display should show after each edge.
  logic [6:0] m_seg;
  logic       m_sv, m_un;
  bit         m_live = 1'b0;

  always @(posedge clk) begin
    if (reset) begin
      m_seg  <= 7'h00;
      m_sv   <= 1'b0;
      m_un   <= 1'b0;
      m_live <= 1'b1;
    end else begin
      m_sv <= ascii_valid;
      if (ascii_valid) begin
        m_seg <= pat_tbl[ascii_code];
        m_un  <= !ok_tbl[ascii_code];
      end
    end
  end

  task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h at %0t", name, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (m_live) begin
      chk("model_seg_lo", {1'b0, seg_lo}, {1'b0, ~m_seg});
      chk("model_seg_hi", {1'b0, seg_hi}, {1'b0, m_seg});
      chk("model_valid",  {6'd0, sv_hi, sv_lo}, {6'd0, m_sv, m_sv});
      chk("model_unsup",  {6'd0, un_hi, un_lo}, {6'd0, m_un, m_un});
    end
  end

  task automatic drive(input logic v, input logic [7:0] c);
    ascii_valid = v;
    ascii_code  = c;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    logic [6:0] sweep [10];
    sweep = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
    build_table();

    reset       = 1'b1;
    ascii_valid = 1'b1;
    ascii_code  = 8'h38;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_seg_lo", {1'b0, seg_lo}, 8'h7F);
    chk("reset_seg_hi", {1'b0, seg_hi}, 8'h00);
    chk("reset_valid",  {7'd0, sv_lo}, 8'h00);
    chk("reset_unsup",  {7'd0, un_lo}, 8'h00);
    reset = 1'b0;

    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 8'h30 + 8'(i));
      chk("sweep_seg", {1'b0, seg_lo}, {1'b0, sweep[i]});
      chk("sweep_valid", {7'd0, sv_lo}, 8'h01);
    end

    drive(1'b1, 8'h41); chk("hex_A", {1'b0, seg_lo}, 8'h08);
    drive(1'b1, 8'h61); chk("hex_a", {1'b0, seg_lo}, 8'h08);
    drive(1'b1, 8'h46); chk("hex_F", {1'b0, seg_lo}, 8'h0E);
    chk("hex_unsup", {7'd0, un_lo}, 8'h00);

    drive(1'b1, 8'h35); chk("hold_load", {1'b0, seg_lo}, 8'h12);
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 8'h31);
      chk("hold_seg", {1'b0, seg_lo}, 8'h12);
      chk("hold_valid", {7'd0, sv_lo}, 8'h00);
    end

    drive(1'b1, 8'h47); chk("unsup_G_seg", {1'b0, seg_lo}, 8'h3F); chk("unsup_G", {7'd0, un_lo}, 8'h01);
    drive(1'b1, 8'hB0); chk("unsup_B0_seg", {1'b0, seg_lo}, 8'h3F); chk("unsup_B0", {7'd0, un_lo}, 8'h01);
    drive(1'b1, 8'h20); chk("space_seg", {1'b0, seg_lo}, 8'h7F); chk("space_unsup", {7'd0, un_lo}, 8'h00);
    drive(1'b1, 8'h2D); chk("dash_seg", {1'b0, seg_lo}, 8'h3F); chk("dash_unsup", {7'd0, un_lo}, 8'h00);

    drive(1'b1, 8'h32); chk("polarity_hi", {1'b0, seg_hi}, 8'h5B);

`ifdef ASCII7SEG_ALPHA_EN
    drive(1'b1, 8'h48); chk("alpha_H", {1'b0, seg_lo}, 8'h09); chk("alpha_H_unsup", {7'd0, un_lo}, 8'h00);
    drive(1'b1, 8'h74); chk("alpha_t", {1'b0, seg_hi}, 8'h78);
`else
    drive(1'b1, 8'h48); chk("noalpha_H", {1'b0, seg_lo}, 8'h3F); chk("noalpha_H_unsup", {7'd0, un_lo}, 8'h01);
`endif

    for (int i = 0; i < 600; i++) begin
      reset = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 1) == 0)
        drive($urandom_range(0, 3) != 0, 8'($urandom_range(0, 255)));
      else
        drive($urandom_range(0, 3) != 0, 8'($urandom_range(8'h20, 8'h7A)));
    end
    reset = 1'b0;
    drive(1'b0, 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ascii_7seg.md
Name: ascii_7seg

Overview:
Registered ASCII-to-seven-segment decoder for one display digit. Converts an 8-bit ASCII code (digits '0'-'9', hex letters A-F/a-f, space) into a 7-bit segment pattern. Sits between a character source (UART/keypad/text buffer) and a single seven-segment digit driver. Unsupported codes show a dash and raise a flag.

Parameters:
ACTIVE_LOW, 1, 1 = segment lit when its bit is 0 (common-anode board displays); 0 = lit when bit is 1.

Ports:
clk  input  1  system clock; all state updates on rising edge
reset  input  1  synchronous, active-high reset
ascii_code  input  8  ASCII character to display
ascii_valid  input  1  load strobe; ascii_code sampled when high
hex_seg  output  7  segment drive; bit0=a, bit1=b, bit2=c, bit3=d, bit4=e, bit5=f, bit6=g
seg_valid  output  1  high for one cycle after each accepted load
unsupported  output  1  high while the displayed code is outside the decoded set

Behaviour:
- One clock, synchronous, active-high reset. Reset has priority over ascii_valid.
- Reset values: hex_seg = blank (7'h7F with ACTIVE_LOW=1, 7'h00 with ACTIVE_LOW=0); seg_valid=0; unsupported=0.
- Latency: 1 cycle. ascii_valid=1 at edge N -> hex_seg, unsupported updated and seg_valid=1 after edge N.
- ascii_valid=0: hex_seg and unsupported hold; seg_valid=0.
- Back-to-back strobes: every cycle accepted, no bubbles.
- Active-high patterns (g..a), inverted when ACTIVE_LOW=1:
  - '0' 0x30 -> 3F; '1' -> 06; '2' -> 5B; '3' -> 4F; '4' -> 66; '5' -> 6D; '6' -> 7D; '7' -> 07; '8' -> 7F; '9' 0x39 -> 6F.
  - 'A'/'a' -> 77; 'B'/'b' -> 7C; 'C'/'c' -> 39; 'D'/'d' -> 5E; 'E'/'e' -> 79; 'F'/'f' -> 71.
  - Space 0x20 -> 00 (blank), unsupported=0.
  - '-' 0x2D -> 40 (dash), unsupported=0.
- Any other code, including bit7=1: dash pattern 40, unsupported=1.
- Decode is purely combinational from ascii_code into the output register; no other state.

Optional Feature:
ASCII7SEG_ALPHA_EN. When defined, extra letters decode (case-insensitive) with unsupported=0:
- H -> 76, L -> 38, P -> 73, U -> 3E, O -> 3F, n -> 54, r -> 50, t -> 78.
- Case-insensitive means both 'H'/'h' etc. map to these patterns.
When undefined, these codes fall into the unsupported path: dash, unsupported=1.

Test Plan:
- Reset: reset=1 for 2 cycles with ascii_valid=1, ascii_code=0x38 -> hex_seg=7F, seg_valid=0, unsupported=0 (ACTIVE_LOW=1).
- Digit sweep: 0x30..0x39, one per cycle, ascii_valid=1 -> hex_seg one cycle later = 40,79,24,30,19,12,02,78,00,10; seg_valid=1 each cycle.
- Hex letters: 0x41 then 0x61 -> 08 both; 0x46 -> 0E; unsupported=0.
- Hold: load 0x35 (hex_seg=12), then ascii_valid=0 with ascii_code=0x31 for 5 cycles -> hex_seg stays 12, seg_valid=0.
- Unsupported: 0x47 'G' and 0xB0 -> hex_seg=3F, unsupported=1. Then 0x20 -> hex_seg=7F, unsupported=0.
- Polarity/feature: ACTIVE_LOW=0, code 0x32 -> 5B. With ASCII7SEG_ALPHA_EN, 0x48 -> hex_seg=09 (ACTIVE_LOW=1), unsupported=0.
